// File: rtl/pbus_arbiter.sv
// pbus_arbiter: two-master round-robin arbiter for the peripheral bus.
// m0 (CPU data port) and m1 (auxiliary master, e.g. UART DMA) share one
// registered rd/wr/addr/wdata slave port, one beat per cycle. A locked owner
// may keep the bus for at most MAX_BURST consecutive beats while the other
// master is waiting.
// Optional build macro: PBUS_STATS_EN adds the gnt_cnt0, gnt_cnt1 and
// conflict_cnt statistics outputs. Arbitration is identical with or without it.
module pbus_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_lock,
   input  logic          m0_rd,
   input  logic          m0_wr,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_done,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_lock,
   input  logic          m1_rd,
   input  logic          m1_wr,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_done,
   output logic [DW-1:0] m1_rdata,
   output logic          s_rd,
   output logic          s_wr,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic [DW-1:0] s_rdata
`ifdef PBUS_STATS_EN
   ,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1,
   output logic [CNT_W-1:0] conflict_cnt
`endif
);

   // Burst counter only needs to reach MAX_BURST-1 (the last beat an owner may take).
   localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

   // Elaboration-time guard against meaningless parameter values.
   generate
      if (MAX_BURST < 1 || CNT_W < 1) begin : g_bad_param
         $error("pbus_arbiter: MAX_BURST and CNT_W must both be >= 1");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic            last_q, last_d;           // master granted most recently (1 = m1)
   logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
   logic [1:0]      gnt_q, gnt_d;
   logic [1:0]      done_q, done_d;
   logic            s_rd_q, s_rd_d;
   logic            s_wr_q, s_wr_d;
   logic [AW-1:0]   s_addr_q, s_addr_d;
   logic [DW-1:0]   s_wdata_q, s_wdata_d;

   logic [1:0]      req_a;
   logic [1:0]      lock_a;
   logic [1:0]      rd_a;
   logic [1:0]      wr_a;
   logic [AW-1:0]   addr_a  [2];
   logic [DW-1:0]   wdata_a [2];
   logic            req_any;
   logic            req_both;
   logic            win;

   // Gather both master ports into indexable form.
   always_comb begin
      req_a      = {m1_req,  m0_req};
      lock_a     = {m1_lock, m0_lock};
      rd_a       = {m1_rd,   m0_rd};
      wr_a       = {m1_wr,   m0_wr};
      addr_a[0]  = m0_addr;
      addr_a[1]  = m1_addr;
      wdata_a[0] = m0_wdata;
      wdata_a[1] = m1_wdata;
   end

   // Arbitration, next state, burst tracking and the next slave beat.
   always_comb begin
      req_any     = |req_a;
      req_both    = &req_a;
      win         = req_a[1] & ~req_a[0];
      state_d     = ST_IDLE;
      last_d      = last_q;
      burst_cnt_d = '0;
      gnt_d       = 2'b00;
      done_d      = 2'b00;
      s_rd_d      = 1'b0;
      s_wr_d      = 1'b0;
      s_addr_d    = '0;
      s_wdata_d   = '0;

      // In ACCESS, last_q is the current owner; lock only matters under contention.
      if (req_both) begin
         if (state_q == ST_ACCESS && lock_a[last_q] && burst_cnt_q < BURST_LAST) begin
            win = last_q;
         end else begin
            win = ~last_q;
         end
      end

      if (req_any) begin
         state_d        = ST_ACCESS;
         last_d         = win;
         gnt_d[win]     = 1'b1;
         // rd together with wr is treated as a write; rd=wr=0 is a null beat.
         s_rd_d         = rd_a[win] & ~wr_a[win];
         s_wr_d         = wr_a[win];
         s_addr_d       = addr_a[win];
         s_wdata_d      = wdata_a[win];
         // Count consecutive beats of one owner, but only while the other one waits.
         if (state_q == ST_ACCESS && win == last_q) begin
            burst_cnt_d = burst_cnt_q;
            if (req_both && burst_cnt_q < BURST_LAST) begin
               burst_cnt_d = burst_cnt_q + BCW'(1);
            end
         end
      end

      // The beat on the slave port this cycle completes at the next edge.
      if (state_q == ST_ACCESS) begin
         done_d = gnt_q;
      end
   end

   // Arbiter state and registered slave command.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         burst_cnt_q <= '0;
         gnt_q       <= 2'b00;
         done_q      <= 2'b00;
         s_rd_q      <= 1'b0;
         s_wr_q      <= 1'b0;
         s_addr_q    <= '0;
         s_wdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         burst_cnt_q <= burst_cnt_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         s_rd_q      <= s_rd_d;
         s_wr_q      <= s_wr_d;
         s_addr_q    <= s_addr_d;
         s_wdata_q   <= s_wdata_d;
      end
   end

   // Per-master read-data capture; the non-granted master holds its value.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_master
         logic [DW-1:0] rdata_q, rdata_d;

         // Capture slave data at the edge ending this master's beat (0 unless a read).
         always_comb begin
            rdata_d = rdata_q;
            if (gnt_q[gi]) begin
               rdata_d = s_rd_q ? s_rdata : '0;
            end
         end

         // Read data register.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               rdata_q <= '0;
            end else begin
               rdata_q <= rdata_d;
            end
         end
      end
   endgenerate

`ifdef PBUS_STATS_EN
   logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
   logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;
   logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

   // Statistics: beats granted per master and contended edges, wrapping.
   always_comb begin
      gnt_cnt0_d     = gnt_cnt0_q     + CNT_W'(gnt_d[0]);
      gnt_cnt1_d     = gnt_cnt1_q     + CNT_W'(gnt_d[1]);
      conflict_cnt_d = conflict_cnt_q + CNT_W'(req_both);
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_cnt0_q     <= '0;
         gnt_cnt1_q     <= '0;
         conflict_cnt_q <= '0;
      end else begin
         gnt_cnt0_q     <= gnt_cnt0_d;
         gnt_cnt1_q     <= gnt_cnt1_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign gnt_cnt0     = gnt_cnt0_q;
   assign gnt_cnt1     = gnt_cnt1_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

   assign m0_gnt   = gnt_q[0];
   assign m1_gnt   = gnt_q[1];
   assign m0_done  = done_q[0];
   assign m1_done  = done_q[1];
   assign m0_rdata = g_master[0].rdata_q;
   assign m1_rdata = g_master[1].rdata_q;
   assign s_rd     = s_rd_q;
   assign s_wr     = s_wr_q;
   assign s_addr   = s_addr_q;
   assign s_wdata  = s_wdata_q;

endmodule

// File: tb/tb_pbus_arbiter.sv
// tb_pbus_arbiter: scoreboard bench for pbus_arbiter. Beats are queued per
// master; the expected read data is pushed when a beat is driven and popped
// on the matching done pulse. Grant order is logged per cycle and compared
// against hand-derived tables.
module tb_pbus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_req, m0_lock, m0_rd, m0_wr;
   logic [31:0] m0_addr, m0_wdata;
   logic        m0_gnt, m0_done;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_lock, m1_rd, m1_wr;
   logic [31:0] m1_addr, m1_wdata;
   logic        m1_gnt, m1_done;
   logic [31:0] m1_rdata;
   logic        s_rd, s_wr;
   logic [31:0] s_addr, s_wdata, s_rdata;
`ifdef PBUS_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic        lock;
      logic [31:0] addr;
      logic [31:0] wdata;
   } beat_t;

   beat_t       beats0[$];
   beat_t       beats1[$];
   beat_t       cur0, cur1;
   logic [31:0] exp0[$];
   logic [31:0] exp1[$];
   int          glog[$];
   int          checks = 0;
   int          errors = 0;
   logic [1:0]  prev_gnt = 2'b00;

   pbus_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_rd(m0_rd), .m0_wr(m0_wr),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_rd(m1_rd), .m1_wr(m1_wr),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
      .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata)
`ifdef PBUS_STATS_EN
      , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Slave register model: combinational read data derived from the address.
   function automatic logic [31:0] slave_fn(input logic [31:0] a);
      return (a == 32'h4000_0010) ? 32'h0000_003C : (a ^ 32'h1234_5678);
   endfunction

   assign s_rdata = slave_fn(s_addr);

   function automatic beat_t mk(input logic rd, input logic wr, input logic lock,
                                input logic [31:0] addr, input logic [31:0] wdata);
      beat_t b;
      b.rd = rd; b.wr = wr; b.lock = lock; b.addr = addr; b.wdata = wdata;
      return b;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic clear_inputs();
      m0_req = 1'b0; m0_lock = 1'b0; m0_rd = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_lock = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
      cur0 = '0; cur1 = '0;
      beats0.delete(); beats1.delete(); exp0.delete(); exp1.delete();
      prev_gnt = 2'b00;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_gnt"},   32'({m1_gnt, m0_gnt}), 32'd0);
      check_val({tag, "_done"},  32'({m1_done, m0_done}), 32'd0);
      check_val({tag, "_sstb"},  32'({s_rd, s_wr}), 32'd0);
      check_val({tag, "_saddr"}, s_addr, 32'd0);
      check_val({tag, "_swdat"}, s_wdata, 32'd0);
   endtask

   // Present the next queued beat of master i (or drop req) and push its expected rdata.
   task automatic load(input int i);
      beat_t b;
      logic  have;
      b = '0;
      if (i == 0) begin
         have = (beats0.size() > 0);
         if (have) begin
            b = beats0.pop_front();
            exp0.push_back((b.rd && !b.wr) ? slave_fn(b.addr) : 32'd0);
         end
         cur0 = b;
         m0_req = have; m0_lock = b.lock; m0_rd = b.rd; m0_wr = b.wr;
         m0_addr = b.addr; m0_wdata = b.wdata;
      end else begin
         have = (beats1.size() > 0);
         if (have) begin
            b = beats1.pop_front();
            exp1.push_back((b.rd && !b.wr) ? slave_fn(b.addr) : 32'd0);
         end
         cur1 = b;
         m1_req = have; m1_lock = b.lock; m1_rd = b.rd; m1_wr = b.wr;
         m1_addr = b.addr; m1_wdata = b.wdata;
      end
   endtask

   task automatic kick();
      if (!m0_req) load(0);
      if (!m1_req) load(1);
   endtask

   task automatic check_beat(input string tag, input beat_t b);
      check_val({tag, "_s_wr"},    32'(s_wr), 32'(b.wr));
      check_val({tag, "_s_rd"},    32'(s_rd), 32'(b.rd & ~b.wr));
      check_val({tag, "_s_addr"},  s_addr, b.addr);
      check_val({tag, "_s_wdata"}, s_wdata, b.wdata);
   endtask

   // One clock cycle: sample at the falling edge, score, then drive the next beats.
   task automatic step();
      logic [1:0] g, d;
      @(negedge clk);
      g = {m1_gnt, m0_gnt};
      d = {m1_done, m0_done};
      check_val("gnt_excl", 32'(g == 2'b11), 32'd0);
      check_val("done_after_gnt", 32'(d), 32'(prev_gnt));
      prev_gnt = g;
      if (g == 2'b00) begin
         glog.push_back(-1);
         check_val("idle_strobes", 32'({s_rd, s_wr}), 32'd0);
      end else if (g[0]) begin
         glog.push_back(0);
         check_beat("m0_beat", cur0);
      end else begin
         glog.push_back(1);
         check_beat("m1_beat", cur1);
      end
      if (d[0]) begin
         if (exp0.size() == 0) check_val("m0_spurious_done", 32'(exp0.size()), 32'd1);
         else check_val("m0_rdata", m0_rdata, exp0.pop_front());
         $display("m0 beat done rdata=%h", m0_rdata);
      end
      if (d[1]) begin
         if (exp1.size() == 0) check_val("m1_spurious_done", 32'(exp1.size()), 32'd1);
         else check_val("m1_rdata", m1_rdata, exp1.pop_front());
         $display("m1 beat done rdata=%h", m1_rdata);
      end
      if (g[0] || !m0_req) load(0);
      if (g[1] || !m1_req) load(1);
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic check_log(input string tag, input int exp_tbl[$]);
      check_val({tag, "_len"}, 32'(glog.size()), 32'(exp_tbl.size()));
      for (int k = 0; k < exp_tbl.size() && k < glog.size(); k++)
         check_val($sformatf("%s_gnt%0d", tag, k), 32'(glog[k]), 32'(exp_tbl[k]));
      check_val({tag, "_drain0"}, 32'(exp0.size()), 32'd0);
      check_val({tag, "_drain1"}, 32'(exp1.size()), 32'd0);
      glog.delete();
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      clear_inputs();
      glog.delete();
      repeat (2) @(negedge clk);
      check_all_zero(tag);
      check_val({tag, "_rdata0"}, m0_rdata, 32'd0);
      check_val({tag, "_rdata1"}, m1_rdata, 32'd0);
`ifdef PBUS_STATS_EN
      check_val({tag, "_stats"}, 32'({gnt_cnt0, gnt_cnt1}), 32'd0);
      check_val({tag, "_conf"},  32'(conflict_cnt), 32'd0);
`endif
      reset = 1'b1;
   endtask

   initial begin
      int t1[$];
      int t2a[$];
      int t2b[$];
      int t3[$];
      int t4[$];
      int t5[$];
      clear_inputs();

      // 1. Lone m0 write: one slave beat, done the cycle after the grant.
      do_reset("rst1");
      beats0.push_back(mk(1'b0, 1'b1, 1'b0, 32'h4000_000C, 32'h0000_00A5));
      kick();
      run_cycles(3);
      t1 = '{0, -1, -1};
      check_log("t1", t1);

      // rd+wr beat (write only), null beat, then a read whose data m0 must keep.
      beats0.push_back(mk(1'b1, 1'b1, 1'b0, 32'h4000_0004, 32'h0000_1111));
      beats0.push_back(mk(1'b0, 1'b0, 1'b0, 32'h4000_0008, 32'h0000_2222));
      beats0.push_back(mk(1'b1, 1'b0, 1'b0, 32'h4000_0020, 32'h0));
      kick();
      run_cycles(5);
      t2a = '{0, 0, 0, -1, -1};
      check_log("t2a", t2a);

      // 2. m1 read of 0x40000010 returns 0x3C; m0 rdata holds.
      beats1.push_back(mk(1'b1, 1'b0, 1'b0, 32'h4000_0010, 32'h0));
      kick();
      run_cycles(3);
      t2b = '{1, -1, -1};
      check_log("t2b", t2b);
      check_val("t2_m1_rdata", m1_rdata, 32'h0000_003C);
      check_val("t2_m0_hold", m0_rdata, slave_fn(32'h4000_0020));

      // 3. Both masters request continuously without lock: strict alternation.
      do_reset("rst3");
      for (int k = 0; k < 4; k++) begin
         beats0.push_back(mk(1'b1, 1'b0, 1'b0, 32'h4000_0040 + 32'(4 * k), 32'h0));
         beats1.push_back(mk(1'b0, 1'b1, 1'b0, 32'h4000_0080 + 32'(4 * k), 32'hBEEF_0000 + 32'(k)));
      end
      kick();
      run_cycles(10);
      t3 = '{0, 1, 0, 1, 0, 1, 0, 1, -1, -1};
      check_log("t3", t3);

      // 4. m1 locked 10-beat burst against a waiting m0: bursts capped at 4 beats.
      do_reset("rst4");
      for (int k = 0; k < 3; k++)
         beats0.push_back(mk(1'b1, 1'b0, 1'b0, 32'h4000_0100 + 32'(4 * k), 32'h0));
      for (int k = 0; k < 10; k++)
         beats1.push_back(mk(1'b0, 1'b1, 1'b1, 32'h4000_0200 + 32'(4 * k), 32'(k)));
      kick();
      run_cycles(14);
      t4 = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, -1};
      check_log("t4", t4);

      // 5. Reset in the middle of a beat clears everything immediately.
      do_reset("rst5");
      beats0.push_back(mk(1'b0, 1'b1, 1'b0, 32'h4000_0300, 32'h0000_0055));
      beats1.push_back(mk(1'b1, 1'b0, 1'b0, 32'h4000_0304, 32'h0));
      kick();
      step();
      check_val("t5_pre_gnt0", 32'(m0_gnt), 32'd1);
      #2 reset = 1'b0;
      #1 check_all_zero("t5_mid");
      clear_inputs();
      glog.delete();
      @(negedge clk);
      reset = 1'b1;
      beats0.push_back(mk(1'b1, 1'b0, 1'b0, 32'h4000_0308, 32'h0));
      beats1.push_back(mk(1'b1, 1'b0, 1'b0, 32'h4000_030C, 32'h0));
      kick();
      run_cycles(4);
      t5 = '{0, 1, -1, -1};
      check_log("t5", t5);

`ifdef PBUS_STATS_EN
      // 6. Statistics: 3 m0 beats, 2 m1 beats, exactly one contended edge.
      do_reset("rst6");
      beats0.push_back(mk(1'b1, 1'b0, 1'b0, 32'h4000_0400, 32'h0));
      beats1.push_back(mk(1'b1, 1'b0, 1'b0, 32'h4000_0404, 32'h0));
      kick();
      run_cycles(2);
      beats0.push_back(mk(1'b0, 1'b1, 1'b0, 32'h4000_0408, 32'h7));
      beats0.push_back(mk(1'b0, 1'b1, 1'b0, 32'h4000_040C, 32'h8));
      kick();
      run_cycles(3);
      beats1.push_back(mk(1'b0, 1'b1, 1'b0, 32'h4000_0410, 32'h9));
      kick();
      run_cycles(3);
      check_val("t6_gnt_cnt0", 32'(gnt_cnt0), 32'd3);
      check_val("t6_gnt_cnt1", 32'(gnt_cnt1), 32'd2);
      check_val("t6_conflict", 32'(conflict_cnt), 32'd1);
      glog.delete();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
